// File: rtl/dcache_mem_bridge.sv
// D-cache line fill / writeback bridge onto a single-word memory request bus.
// Defining DCACHE_MEM_BRIDGE_PERF_EN adds fill/writeback performance counters.
module dcache_mem_bridge #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int ADDRESS_WIDTH = 32,
   parameter  int BLOCK_SIZE    = 32,
   localparam int OFFSET_WIDTH  = $clog2(DATA_WIDTH*BLOCK_SIZE/8),
   localparam int LINE_W        = DATA_WIDTH*BLOCK_SIZE,
   localparam int LA_W          = ADDRESS_WIDTH-OFFSET_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ADDR_TO_L2_VALID,
   input  logic [LA_W-1:0]          ADDR_TO_L2,
   output logic [LINE_W-1:0]        DATA_FROM_L2,
   output logic                     DATA_FROM_L2_VALID,
   input  logic                     DATA_TO_L2_VALID,
   input  logic [LINE_W-1:0]        DATA_TO_L2,
   input  logic [LA_W-1:0]          WADDR_TO_L2,
   output logic                     WRITE_DONE,
   output logic                     MEM_REQ_VALID,
   input  logic                     MEM_REQ_READY,
   output logic                     MEM_REQ_WE,
   output logic [ADDRESS_WIDTH-1:0] MEM_REQ_ADDR,
   output logic [DATA_WIDTH-1:0]    MEM_REQ_WDATA,
   input  logic                     MEM_RESP_VALID,
   input  logic [DATA_WIDTH-1:0]    MEM_RESP_DATA,
   output logic [31:0]              PERF_FILLS,
   output logic [31:0]              PERF_WBS
);

   // state      | meaning
   // IDLE       | wait for writeback edge (priority) or pending fill
   // WB_ISSUE   | issue write beats, one per handshake
   // WB_DRAIN   | all writes issued, collecting remaining acks
   // FILL_ISSUE | issue read beats, one per handshake
   // FILL_DRAIN | all reads issued, collecting remaining data
   // DONE       | line complete, pulse valid and release pending fill
   typedef enum logic [2:0] {IDLE, WB_ISSUE, WB_DRAIN, FILL_ISSUE, FILL_DRAIN, DONE} state_t;

   localparam int               CNT_W = $clog2(BLOCK_SIZE) + 1;
   localparam int               BI_W  = OFFSET_WIDTH - 2;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_SIZE - 1);

   state_t                   r_state;
   logic [CNT_W-1:0]         r_beat, r_resp;
   logic                     r_dv_q, r_fill_pend;
   logic [LA_W-1:0]          r_fill_addr, r_line_addr;
   logic [LINE_W-1:0]        r_wb_line, r_fill_data;
   logic                     r_req_valid, r_req_we;
   logic [ADDRESS_WIDTH-1:0] r_req_addr;
   logic [DATA_WIDTH-1:0]    r_req_wdata;
   logic                     r_data_valid, r_write_done;

   logic             w_wb_edge, w_hs, w_last_beat, w_xfer, w_resp_cnt, w_resp_last, w_is_fill;
   logic [CNT_W-1:0] w_beat_nxt;

   assign w_wb_edge   = (r_state == IDLE) && DATA_TO_L2_VALID && !r_dv_q;
   assign w_hs        = r_req_valid && MEM_REQ_READY;
   assign w_last_beat = (r_beat == LAST);
   assign w_xfer      = r_state inside {WB_ISSUE, WB_DRAIN, FILL_ISSUE, FILL_DRAIN};
   assign w_is_fill   = r_state inside {FILL_ISSUE, FILL_DRAIN};
   assign w_resp_cnt  = MEM_RESP_VALID && w_xfer;
   assign w_resp_last = w_resp_cnt && (r_resp == LAST);
   assign w_beat_nxt  = r_beat + CNT_W'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= IDLE;
         r_beat       <= '0;
         r_resp       <= '0;
         r_dv_q       <= 1'b0;
         r_fill_pend  <= 1'b0;
         r_fill_addr  <= '0;
         r_line_addr  <= '0;
         r_wb_line    <= '0;
         r_fill_data  <= '0;
         r_req_valid  <= 1'b0;
         r_req_we     <= 1'b0;
         r_req_addr   <= '0;
         r_req_wdata  <= '0;
         r_data_valid <= 1'b0;
         r_write_done <= 1'b0;
      end else begin
         r_dv_q       <= DATA_TO_L2_VALID;
         r_data_valid <= 1'b0;
         r_write_done <= 1'b0;
         if (ADDR_TO_L2_VALID && !r_fill_pend) begin
            r_fill_pend <= 1'b1;
            r_fill_addr <= ADDR_TO_L2;
         end
         // Responses are counted on their own; requests may still be in flight.
         if (w_resp_cnt) r_resp <= r_resp + CNT_W'(1);
         if (w_resp_cnt && w_is_fill) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
               if (r_resp == CNT_W'(i)) r_fill_data[i*DATA_WIDTH +: DATA_WIDTH] <= MEM_RESP_DATA;
         end
         case (r_state)
            IDLE: begin
               r_beat <= '0;
               r_resp <= '0;
               if (w_wb_edge) begin
                  r_wb_line   <= DATA_TO_L2;
                  r_line_addr <= WADDR_TO_L2;
                  r_req_valid <= 1'b1;
                  r_req_we    <= 1'b1;
                  r_req_addr  <= {WADDR_TO_L2, {BI_W{1'b0}}, 2'b00};
                  r_req_wdata <= DATA_TO_L2[DATA_WIDTH-1:0];
                  r_state     <= WB_ISSUE;
               end else if (r_fill_pend) begin
                  r_line_addr <= r_fill_addr;
                  r_req_valid <= 1'b1;
                  r_req_we    <= 1'b0;
                  r_req_addr  <= {r_fill_addr, {BI_W{1'b0}}, 2'b00};
                  r_req_wdata <= '0;
                  r_state     <= FILL_ISSUE;
               end
            end
            WB_ISSUE, FILL_ISSUE: begin
               if (w_hs) begin
                  if (w_last_beat) begin
                     r_req_valid <= 1'b0;
                     if (w_resp_last && !w_is_fill) begin
                        r_write_done <= 1'b1;
                        r_state      <= IDLE;
                     end else if (w_resp_last) begin
                        r_data_valid <= 1'b1;
                        r_state      <= DONE;
                     end else begin
                        r_state <= w_is_fill ? FILL_DRAIN : WB_DRAIN;
                     end
                  end else begin
                     // Writeback line shifts down so the next word is always at the bottom.
                     r_beat      <= w_beat_nxt;
                     r_req_addr  <= {r_line_addr, w_beat_nxt[BI_W-1:0], 2'b00};
                     r_wb_line   <= r_wb_line >> DATA_WIDTH;
                     r_req_wdata <= w_is_fill ? '0 : r_wb_line[2*DATA_WIDTH-1:DATA_WIDTH];
                  end
               end
            end
            WB_DRAIN: begin
               if (w_resp_last) begin
                  r_write_done <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            FILL_DRAIN: begin
               if (w_resp_last) begin
                  r_data_valid <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               r_fill_pend <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign DATA_FROM_L2       = r_fill_data;
   assign DATA_FROM_L2_VALID = r_data_valid;
   assign WRITE_DONE         = r_write_done;
   assign MEM_REQ_VALID      = r_req_valid;
   assign MEM_REQ_WE         = r_req_we;
   assign MEM_REQ_ADDR       = r_req_addr;
   assign MEM_REQ_WDATA      = r_req_wdata;

`ifdef DCACHE_MEM_BRIDGE_PERF_EN
   logic [31:0] r_perf_fills, r_perf_wbs;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_perf_fills <= '0;
         r_perf_wbs   <= '0;
      end else begin
         if (r_data_valid) r_perf_fills <= r_perf_fills + 32'd1;
         if (r_write_done) r_perf_wbs   <= r_perf_wbs + 32'd1;
      end
   end

   assign PERF_FILLS = r_perf_fills;
   assign PERF_WBS   = r_perf_wbs;
`else
   assign PERF_FILLS = '0;
   assign PERF_WBS   = '0;
`endif

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Bench for dcache_mem_bridge: in-order request scoreboard, 1-cycle-latency memory model,
// directed fill/writeback/reset/ordering sequence.
module tb_dcache_mem_bridge;
   localparam int  DW = 32, AW = 32, BS = 32, LW = DW*BS, LAW = 25;
   localparam time PERIOD = 10;

   logic           CLK = 1'b0;
   logic           RST;
   logic           ADDR_TO_L2_VALID;
   logic [LAW-1:0] ADDR_TO_L2;
   logic [LW-1:0]  DATA_FROM_L2;
   logic           DATA_FROM_L2_VALID;
   logic           DATA_TO_L2_VALID;
   logic [LW-1:0]  DATA_TO_L2;
   logic [LAW-1:0] WADDR_TO_L2;
   logic           WRITE_DONE;
   logic           MEM_REQ_VALID, MEM_REQ_READY, MEM_REQ_WE;
   logic [AW-1:0]  MEM_REQ_ADDR;
   logic [DW-1:0]  MEM_REQ_WDATA;
   logic           MEM_RESP_VALID;
   logic [DW-1:0]  MEM_RESP_DATA;
   logic [31:0]    PERF_FILLS, PERF_WBS;

   dcache_mem_bridge dut (
      .CLK(CLK), .RST(RST),
      .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID), .ADDR_TO_L2(ADDR_TO_L2),
      .DATA_FROM_L2(DATA_FROM_L2), .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID),
      .DATA_TO_L2_VALID(DATA_TO_L2_VALID), .DATA_TO_L2(DATA_TO_L2),
      .WADDR_TO_L2(WADDR_TO_L2), .WRITE_DONE(WRITE_DONE),
      .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_READY(MEM_REQ_READY),
      .MEM_REQ_WE(MEM_REQ_WE), .MEM_REQ_ADDR(MEM_REQ_ADDR), .MEM_REQ_WDATA(MEM_REQ_WDATA),
      .MEM_RESP_VALID(MEM_RESP_VALID), .MEM_RESP_DATA(MEM_RESP_DATA),
      .PERF_FILLS(PERF_FILLS), .PERF_WBS(PERF_WBS)
   );

   always #(PERIOD/2) CLK = ~CLK;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   req_t          sb[$];
   logic [AW-1:0] rq[$];
   logic [LW-1:0] exp_line;
   int            n_asserts = 0, n_fail = 0;
   int            wd_cnt = 0, wd_sb_left = 0;
   logic          wd_req_valid = 1'b0;
   bit            rnd_ready = 0, spur = 0;
   time           last_resp_t = 0;

   function automatic logic [AW-1:0] baddr(input logic [LAW-1:0] la, input int k);
      return {la, k[4:0], 2'b00};
   endfunction

   function automatic logic [DW-1:0] f_resp(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      int bad = 0;
      for (int k = BS-1; k >= 0; k--) if (obs[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: word %0d observed %h expected %h", tag, bad, obs[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   task automatic push_fill(input logic [LAW-1:0] la);
      for (int k = 0; k < BS; k++) begin
         sb.push_back('{1'b0, baddr(la, k), 32'h0});
         exp_line[k*DW +: DW] = f_resp(baddr(la, k));
      end
   endtask

   task automatic push_wb(input logic [LAW-1:0] la, input logic [LW-1:0] line);
      for (int k = 0; k < BS; k++) sb.push_back('{1'b1, baddr(la, k), line[k*DW +: DW]});
   endtask

   task automatic wait_dv(input string tag);
      bit got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge CLK);
         if (DATA_FROM_L2_VALID) got = 1;
      end
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_latency"}, 64'($time - last_resp_t), 64'(PERIOD));
      chk_line({tag, "_line"}, DATA_FROM_L2, exp_line);
      @(negedge CLK);
      chk({tag, "_dv_pulse"}, 64'(DATA_FROM_L2_VALID), '0);
   endtask

   task automatic wait_wd(input string tag);
      bit got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge CLK);
         if (WRITE_DONE) got = 1;
      end
      chk({tag, "_done"}, 64'(got), 64'd1);
      wd_sb_left   = sb.size();
      wd_req_valid = MEM_REQ_VALID;
      @(negedge CLK);
      chk({tag, "_wd_pulse"}, 64'(WRITE_DONE), '0);
   endtask

   task automatic check_reset(input string p);
      chk({p, "_req_valid"}, 64'(MEM_REQ_VALID), '0);
      chk({p, "_req_we"}, 64'(MEM_REQ_WE), '0);
      chk({p, "_req_addr"}, 64'(MEM_REQ_ADDR), '0);
      chk({p, "_req_wdata"}, 64'(MEM_REQ_WDATA), '0);
      chk({p, "_dv"}, 64'(DATA_FROM_L2_VALID), '0);
      chk({p, "_wd"}, 64'(WRITE_DONE), '0);
      chk({p, "_perf_fills"}, 64'(PERF_FILLS), '0);
      chk({p, "_perf_wbs"}, 64'(PERF_WBS), '0);
      chk_line({p, "_line"}, DATA_FROM_L2, '0);
   endtask

   // Memory model: checks every handshake against the scoreboard, answers one cycle later.
   initial begin
      req_t          e;
      bit            stall = 0;
      logic          h_we;
      logic [AW-1:0] h_addr;
      logic [DW-1:0] h_wdata;
      MEM_REQ_READY  = 1'b1;
      MEM_RESP_VALID = 1'b0;
      MEM_RESP_DATA  = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            sb.delete();
            rq.delete();
            MEM_RESP_VALID = 1'b0;
            MEM_REQ_READY  = 1'b1;
            stall = 0;
         end else begin
            if (WRITE_DONE) wd_cnt++;
            if (rq.size() > 0) begin
               MEM_RESP_VALID = 1'b1;
               MEM_RESP_DATA  = f_resp(rq.pop_front());
               last_resp_t    = $time;
            end else if (spur) begin
               MEM_RESP_VALID = 1'b1;
               MEM_RESP_DATA  = 32'hDEAD_BEEF;
               spur = 0;
            end else begin
               MEM_RESP_VALID = 1'b0;
            end
            if (stall) begin
               chk("stall_valid", 64'(MEM_REQ_VALID), 64'd1);
               chk("stall_addr", 64'(MEM_REQ_ADDR), 64'(h_addr));
               chk("stall_we", 64'(MEM_REQ_WE), 64'(h_we));
               chk("stall_wdata", 64'(MEM_REQ_WDATA), 64'(h_wdata));
            end
            MEM_REQ_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stall   = MEM_REQ_VALID && !MEM_REQ_READY;
            h_we    = MEM_REQ_WE;
            h_addr  = MEM_REQ_ADDR;
            h_wdata = MEM_REQ_WDATA;
            if (MEM_REQ_VALID && MEM_REQ_READY) begin
               chk("req_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("req_addr", 64'(MEM_REQ_ADDR), 64'(e.addr));
                  chk("req_we", 64'(MEM_REQ_WE), 64'(e.we));
                  if (e.we) chk("req_wdata", 64'(MEM_REQ_WDATA), 64'(e.wdata));
               end
               rq.push_back(MEM_REQ_ADDR);
            end
         end
      end
   end

   initial begin
      logic [LW-1:0] line_a, line_b;
      int            wd0;
      bit            got;
      RST = 1'b1;
      ADDR_TO_L2_VALID = 1'b0;
      ADDR_TO_L2 = '0;
      DATA_TO_L2_VALID = 1'b0;
      DATA_TO_L2 = '0;
      WADDR_TO_L2 = '0;
      repeat (3) @(negedge CLK);
      check_reset("rst");
      RST = 1'b0;

      // Plain fill at line 0x10 -> beats 0x800..0x87C
      @(negedge CLK);
      ADDR_TO_L2 = 25'h10; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h10);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_dv("fill1");
      line_a = exp_line;

      // Writeback with a 5-cycle request level
      for (int k = 0; k < BS; k++) line_b[k*DW +: DW] = 32'hB0B0_0000 + 32'(k);
      wd0 = wd_cnt;
      WADDR_TO_L2 = 25'h2; DATA_TO_L2 = line_b; DATA_TO_L2_VALID = 1'b1; push_wb(25'h2, line_b);
      repeat (5) @(negedge CLK);
      DATA_TO_L2_VALID = 1'b0;
      wait_wd("wb1");
      repeat (10) @(negedge CLK);
      chk("wb1_done_count", 64'(wd_cnt - wd0), 64'd1);
      chk("wb1_sb_empty", 64'(sb.size()), '0);
      chk_line("fill_hold", DATA_FROM_L2, line_a);

      // Stray response while idle must not be counted
      spur = 1;
      repeat (3) @(negedge CLK);

      // Fill requested during writeback beat 10; level stays high throughout
      for (int k = 0; k < BS; k++) line_b[k*DW +: DW] = 32'hC3C3_0000 ^ 32'(k * 7);
      WADDR_TO_L2 = 25'h3; DATA_TO_L2 = line_b; DATA_TO_L2_VALID = 1'b1; push_wb(25'h3, line_b);
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLK);
         if (MEM_REQ_VALID && MEM_REQ_ADDR == baddr(25'h3, 10)) got = 1;
      end
      chk("wb2_beat10_seen", 64'(got), 64'd1);
      ADDR_TO_L2 = 25'h20; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h20);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_wd("wb2");
      chk("wb2_fill_waits_sb", 64'(wd_sb_left), 64'(BS));
      chk("wb2_fill_waits_valid", 64'(wd_req_valid), '0);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge CLK);
         if (MEM_REQ_VALID && !MEM_REQ_WE) got = 1;
      end
      chk("fill2_started", 64'(got), 64'd1);
      ADDR_TO_L2 = 25'h30; ADDR_TO_L2_VALID = 1'b1;
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_dv("fill2");
      repeat (10) @(negedge CLK);
      chk("level_no_retrigger", 64'(sb.size()), '0);
      DATA_TO_L2_VALID = 1'b0;

      // Random READY backpressure
      rnd_ready = 1;
      for (int k = 0; k < BS; k++) line_b[k*DW +: DW] = $urandom;
      @(negedge CLK);
      WADDR_TO_L2 = 25'h5; DATA_TO_L2 = line_b; DATA_TO_L2_VALID = 1'b1; push_wb(25'h5, line_b);
      @(negedge CLK);
      DATA_TO_L2_VALID = 1'b0;
      wait_wd("wb3");
      ADDR_TO_L2 = 25'h44; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h44);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_dv("fill3");
      rnd_ready = 0;
      repeat (3) @(negedge CLK);
      chk("rnd_sb_empty", 64'(sb.size()), '0);

      // Reset in the middle of a fill at beat 17
      ADDR_TO_L2 = 25'h50; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h50);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge CLK);
         if (MEM_REQ_VALID && MEM_REQ_ADDR == baddr(25'h50, 17)) got = 1;
      end
      chk("fill4_beat17_seen", 64'(got), 64'd1);
      RST = 1'b1;
      @(negedge CLK);
      check_reset("mid_rst");
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Post-reset traffic: 3 fills, 2 writebacks, one writeback racing a fill
      ADDR_TO_L2 = 25'h60; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h60);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_dv("fill5");
      WADDR_TO_L2 = 25'h61; DATA_TO_L2 = line_b; DATA_TO_L2_VALID = 1'b1; push_wb(25'h61, line_b);
      ADDR_TO_L2 = 25'h62; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h62);
      @(negedge CLK);
      DATA_TO_L2_VALID = 1'b0; ADDR_TO_L2_VALID = 1'b0;
      wait_wd("wb4");
      wait_dv("fill6");
      line_b = ~line_b;
      WADDR_TO_L2 = 25'h63; DATA_TO_L2 = line_b; DATA_TO_L2_VALID = 1'b1; push_wb(25'h63, line_b);
      @(negedge CLK);
      DATA_TO_L2_VALID = 1'b0;
      wait_wd("wb5");
      ADDR_TO_L2 = 25'h64; ADDR_TO_L2_VALID = 1'b1; push_fill(25'h64);
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
      wait_dv("fill7");
      repeat (5) @(negedge CLK);
`ifdef DCACHE_MEM_BRIDGE_PERF_EN
      chk("perf_fills", 64'(PERF_FILLS), 64'd3);
      chk("perf_wbs", 64'(PERF_WBS), 64'd2);
`else
      chk("perf_fills", 64'(PERF_FILLS), '0);
      chk("perf_wbs", 64'(PERF_WBS), '0);
`endif
      chk("final_sb_empty", 64'(sb.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_mem_bridge.md
DCACHE_MEM_BRIDGE -- requirements
Module: dcache_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory-bus word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 32, words per cache line; OFFSET_WIDTH = clog2(DATA_WIDTH*BLOCK_SIZE/8); LINE_W = DATA_WIDTH*BLOCK_SIZE; LA_W = ADDRESS_WIDTH-OFFSET_WIDTH.
REQ-004 SHALL have ports, each as name, direction, width, meaning:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADDR_TO_L2_VALID  in  1  fill request pulse from D-cache.
- ADDR_TO_L2  in  LA_W  line address to fill.
- DATA_FROM_L2  out  LINE_W  assembled fill line.
- DATA_FROM_L2_VALID  out  1  one-cycle fill-complete pulse.
- DATA_TO_L2_VALID  in  1  writeback request level.
- DATA_TO_L2  in  LINE_W  dirty line.
- WADDR_TO_L2  in  LA_W  writeback line address.
- WRITE_DONE  out  1  one-cycle writeback-complete pulse.
- MEM_REQ_VALID / MEM_REQ_READY  out / in  1 / 1  memory request handshake.
- MEM_REQ_WE  out  1  1 = write beat.
- MEM_REQ_ADDR  out  ADDRESS_WIDTH  word-aligned beat byte address.
- MEM_REQ_WDATA  out  DATA_WIDTH  write beat data.
- MEM_RESP_VALID  in  1  one response per request, in order; write responses are acks.
- MEM_RESP_DATA  in  DATA_WIDTH  read beat data.
- PERF_FILLS, PERF_WBS  out  32 each  performance counters.

Function
REQ-005 SHALL implement FSM states IDLE, WB_ISSUE, WB_DRAIN, FILL_ISSUE, FILL_DRAIN, DONE.
REQ-006 SHALL latch a writeback (line and address) on a 0->1 transition of DATA_TO_L2_VALID, sampled only in IDLE; a level that stays high SHALL NOT retrigger.
REQ-007 SHALL latch ADDR_TO_L2 into a pending-fill register on any cycle ADDR_TO_L2_VALID=1, in any state; a second pulse while a fill is pending or active SHALL be ignored.
REQ-008 IDLE: if a writeback is latched, go to WB_ISSUE; otherwise, if a fill is pending, go to FILL_ISSUE. Writeback has priority when both arrive in the same cycle.
REQ-009 Beat k (0..BLOCK_SIZE-1) SHALL use MEM_REQ_ADDR = {line_addr, k[OFFSET_WIDTH-3:0], 2'b00} and MEM_REQ_WDATA = line[k*DATA_WIDTH +: DATA_WIDTH], in ascending order.
REQ-010 ISSUE states: assert MEM_REQ_VALID; address, data and WE SHALL stay stable until MEM_REQ_READY=1; the beat counter increments on each handshake; go to the DRAIN state after the last beat.
REQ-011 SHALL count responses independently of issued beats (outstanding requests allowed); a response arriving in the same cycle as a request handshake SHALL be counted.
REQ-012 Fill responses SHALL write MEM_RESP_DATA into DATA_FROM_L2 word slot equal to the response count.
REQ-013 WB_DRAIN: after the BLOCK_SIZE-th ack, pulse WRITE_DONE for one cycle, then return to IDLE; a pending fill SHALL then proceed.
REQ-014 FILL_DRAIN: after the BLOCK_SIZE-th response, go to DONE; DONE pulses DATA_FROM_L2_VALID for one cycle, clears the pending fill, and returns to IDLE.
REQ-015 DATA_FROM_L2 SHALL hold its last value until the next fill's first response.
REQ-016 MEM_RESP_VALID in IDLE or DONE SHALL be ignored.

Reset
REQ-017 RST SHALL force IDLE, including mid-transfer, and clear beat and response counters, pending-fill and writeback latches, and the edge-detect register.
REQ-018 On RST: MEM_REQ_VALID=0, MEM_REQ_WE=0, MEM_REQ_ADDR=0, MEM_REQ_WDATA=0, DATA_FROM_L2=0, DATA_FROM_L2_VALID=0, WRITE_DONE=0, PERF_FILLS=0, PERF_WBS=0.

Configuration
REQ-019 With macro DCACHE_MEM_BRIDGE_PERF_EN defined, PERF_FILLS SHALL increment on each DATA_FROM_L2_VALID pulse and PERF_WBS on each WRITE_DONE pulse, wrapping at 2^32.
REQ-020 Without DCACHE_MEM_BRIDGE_PERF_EN, both ports SHALL exist and be tied to 0 with no counter logic.

Verification
REQ-021 Fill, READY=1, responses one cycle after each request, ADDR_TO_L2=0x0000010 -> addresses 0x800..0x87C; DATA_FROM_L2_VALID one cycle after the 32nd response; word k = response k.
REQ-022 Writeback WADDR=0x0000002 with DATA_TO_L2_VALID high for 5 cycles -> exactly 32 writes at 0x100..0x17C; exactly one WRITE_DONE.
REQ-023 Fill pulse arriving during writeback beat 10 -> fill beats start only after WRITE_DONE; fill completes.
REQ-024 MEM_REQ_READY toggled 0/1 pseudo-randomly -> request fields stable while VALID=1 and READY=0; no beat lost or duplicated.
REQ-025 RST asserted at fill beat 17 -> next cycle all outputs per REQ-018; a new fill afterwards completes correctly.
REQ-026 With PERF_EN, 3 fills and 2 writebacks -> PERF_FILLS=3, PERF_WBS=2; without PERF_EN -> both 0.
